capture_sequencer: RTL
======================

Name: capture_sequencer

Overview:
- Control FSM for the sampler capture path: arm, wait for trigger, post-trigger delay count, optional RLE flush, then readback of captured words to the SPI transmitter.
- Owns the sample-memory write and read pointers. It sits between the trigger/RLE encoder output and the sample memory plus transmitter.
- Host commands arrive as single-cycle pulses from the SPI command decoder.

Parameters:
- CW, 16, width of the delay_count and read_count operands.
- AW, 10, sample memory address width (memory depth 2^AW words).

Ports:
- clock  in  1  system clock (sampleClock domain)
- reset_n  in  1  asynchronous active-low reset
- cmd_arm  in  1  pulse: start capture
- cmd_abort  in  1  pulse: abandon any operation, return to IDLE
- delay_count  in  CW  post-trigger samples to store; sampled on cmd_arm
- read_count  in  CW  words to read back; sampled on cmd_arm
- trigger_in  in  1  trigger match, qualified by validIn
- validIn  in  1  sample/RLE word valid this cycle
- rle_busy  in  1  RLE encoder still emitting after flush
- rd_ack  in  1  transmitter consumed the current read word
- mem_wr  out  1  write strobe, equal to validIn while capturing
- mem_wraddr  out  AW  write pointer
- rd_req  out  1  read word request to transmitter
- rd_addr  out  AW  read address
- rle_flush  out  1  one-cycle flush pulse to the RLE encoder
- armed  out  1  high in ARMED state
- triggered  out  1  high from trigger until return to IDLE
- done  out  1  one-cycle pulse when readback completes

Behaviour:
- Reset: state IDLE. All outputs 0. wr_ptr=0, rd_ptr=0, delay counter 0, read counter 0.
- States: IDLE, ARMED, DELAY, FLUSH, READ.
- IDLE:
  - cmd_arm latches delay_count and read_count and enters ARMED next cycle.
  - wr_ptr is not cleared on arm; it continues from its last value (circular buffer).
- ARMED: mem_wr=validIn. wr_ptr increments by 1 per valid word and wraps mod 2^AW.
- Trigger: validIn&&trigger_in in ARMED.
  - That sample is written.
  - triggered rises next cycle.
  - If latched delay==0, go to FLUSH; otherwise go to DELAY with remaining=delay.
- DELAY:
  - Each valid sample is written and decrements remaining.
  - The write that brings remaining to 0 is the last; go to FLUSH next cycle.
  - Total stored post-trigger samples = delay+1, including the trigger sample.
- FLUSH:
  - rle_flush pulses for one cycle on entry.
  - mem_wr continues with validIn (encoder tail words) until rle_busy is sampled low at least one cycle after the pulse; then go to READ.
  - Load rd_ptr = wr_ptr-1 (mod 2^AW) and rd_remaining = read_count.
- READ (readback is newest-first):
  - If rd_remaining==0 on entry, go straight to IDLE with the done pulse.
  - Otherwise rd_req=1 with rd_addr=rd_ptr, held stable until rd_ack.
  - On the rd_ack cycle: rd_ptr decrements (wraps 0 -> 2^AW-1), rd_remaining decrements, and rd_req drops for exactly one cycle before the next word is presented.
  - After the last ack: done=1 for one cycle, return to IDLE, triggered clears.
- read_count > 2^AW: the pointer wraps, and old words are re-read. This is legal and not flagged.
- cmd_abort in any state: next cycle IDLE. rd_req, rle_flush, armed and triggered go to 0. done is not pulsed. Pointers hold.
- cmd_arm outside IDLE is ignored. cmd_arm and cmd_abort in the same cycle: abort wins.
- rd_ack without rd_req is ignored.
- Asynchronous reset mid-operation forces the reset state immediately. The registered outputs guarantee no glitch pulses on done or rle_flush.

Optional Feature:
- Macro: CAPTURE_SEQ_RLE_FLUSH_EN.
- Defined: FLUSH state behaves as above.
- Undefined: FLUSH state and the rle_busy input logic are removed. rle_flush is tied 0 and rle_busy is ignored. DELAY/trigger completion goes directly to READ.

Test Plan:
- Reset, AW=4, arm, delay_count=3, read_count=6, trigger on the 10th valid sample:
  - wr_ptr=13 at end of DELAY.
  - Reads come back at addresses 12,11,10,9,8,7.
  - done pulses once.
- delay_count=0, trigger on the first valid sample after arm:
  - Exactly one post-trigger write.
  - triggered=1 the next cycle.
  - With flush enabled, rle_flush pulses the next cycle.
- Flush enabled, rle_busy held high for 5 cycles with validIn=1:
  - 5 extra words written.
  - READ starts only after rle_busy falls.
  - The first rd_addr is the last flushed word.
- Wrap check, AW=4, wr_ptr=1 at READ entry, read_count=4: rd_addr sequence is 0, 15, 14, 13.
- cmd_abort during READ with 2 words remaining:
  - rd_req=0 the next cycle and state is IDLE.
  - done is never asserted.
  - A subsequent cmd_arm is accepted.
- read_count=0: READ → IDLE with done pulsed one cycle and no rd_req ever asserted.

Source files
------------

// File: rtl/capture_sequencer_if.sv
// ============================================================================
// Module      : capture_sequencer_if
// Description : Command, capture and readback signal bundle for capture_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface capture_sequencer_if #(
  parameter int CW = 16,
  parameter int AW = 10
) ();
  logic          cmd_arm;
  logic          cmd_abort;
  logic [CW-1:0] delay_count;
  logic [CW-1:0] read_count;
  logic          trigger_in;
  logic          validIn;
  logic          rle_busy;
  logic          rd_ack;
  logic          mem_wr;
  logic [AW-1:0] mem_wraddr;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rle_flush;
  logic          armed;
  logic          triggered;
  logic          done;

  modport slave (
    input  cmd_arm, cmd_abort, delay_count, read_count,
    input  trigger_in, validIn, rle_busy, rd_ack,
    output mem_wr, mem_wraddr, rd_req, rd_addr,
    output rle_flush, armed, triggered, done
  );

  modport master (
    output cmd_arm, cmd_abort, delay_count, read_count,
    output trigger_in, validIn, rle_busy, rd_ack,
    input  mem_wr, mem_wraddr, rd_req, rd_addr,
    input  rle_flush, armed, triggered, done
  );
endinterface

`default_nettype wire

// File: rtl/capture_sequencer.sv
// ============================================================================
// Module      : capture_sequencer
// Description : Arm/trigger/delay/flush/readback control for the sample memory.
//               Define CAPTURE_SEQ_RLE_FLUSH_EN to include the RLE flush state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module capture_sequencer #(
  parameter int CW = 16,
  parameter int AW = 10
) (
  input  logic                clock,
  input  logic                reset_n,
  capture_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_FLUSH = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] dly_q, dly_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          triggered_q, triggered_d;
  logic          rle_flush_q, rle_flush_d;
  logic          rd_req_q, rd_req_d;
  logic          done_q, done_d;
  logic          mem_wr_w;
  logic [AW-1:0] wr_next_w;

  // Pointer after this cycle's write; valid wherever mem_wr follows validIn.
  assign wr_next_w = wr_ptr_q + {{(AW-1){1'b0}}, bus.validIn};

`ifndef CAPTURE_SEQ_RLE_FLUSH_EN
  logic unused_rle_busy;
  assign unused_rle_busy = bus.rle_busy;
`endif

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    dly_d       = dly_q;
    rem_d       = rem_q;
    triggered_d = triggered_q;
    rle_flush_d = 1'b0;
    rd_req_d    = rd_req_q;
    done_d      = 1'b0;
    mem_wr_w    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_arm) begin
          dly_d   = bus.delay_count;
          rem_d   = bus.read_count;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        mem_wr_w = bus.validIn;
        if (bus.validIn && bus.trigger_in) begin
          triggered_d = 1'b1;
          if (dly_q == '0) begin
`ifdef CAPTURE_SEQ_RLE_FLUSH_EN
            state_d     = S_FLUSH;
            rle_flush_d = 1'b1;
`else
            state_d  = S_READ;
            rd_ptr_d = wr_next_w - AW'(1);
`endif
          end else begin
            state_d = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        mem_wr_w = bus.validIn;
        if (bus.validIn) begin
          dly_d = dly_q - CW'(1);
          if (dly_q == CW'(1)) begin
`ifdef CAPTURE_SEQ_RLE_FLUSH_EN
            state_d     = S_FLUSH;
            rle_flush_d = 1'b1;
`else
            state_d  = S_READ;
            rd_ptr_d = wr_next_w - AW'(1);
`endif
          end
        end
      end
`ifdef CAPTURE_SEQ_RLE_FLUSH_EN
      S_FLUSH: begin
        mem_wr_w = bus.validIn;
        // rle_flush_q marks the pulse cycle; busy is only trusted after it.
        if (!rle_flush_q && !bus.rle_busy) begin
          state_d  = S_READ;
          rd_ptr_d = wr_next_w - AW'(1);
        end
      end
`endif
      S_READ: begin
        if (rem_q == '0) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          triggered_d = 1'b0;
          rd_req_d    = 1'b0;
        end else if (rd_req_q) begin
          if (bus.rd_ack) begin
            rd_req_d = 1'b0;
            rd_ptr_d = rd_ptr_q - AW'(1);
            rem_d    = rem_q - CW'(1);
            if (rem_q == CW'(1)) begin
              state_d     = S_IDLE;
              done_d      = 1'b1;
              triggered_d = 1'b0;
            end
          end
        end else begin
          rd_req_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.cmd_abort) begin
      state_d     = S_IDLE;
      rd_ptr_d    = rd_ptr_q;
      triggered_d = 1'b0;
      rle_flush_d = 1'b0;
      rd_req_d    = 1'b0;
      done_d      = 1'b0;
      mem_wr_w    = 1'b0;
    end

    wr_ptr_d = mem_wr_w ? wr_next_w : wr_ptr_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dly_q       <= '0;
      rem_q       <= '0;
      triggered_q <= 1'b0;
      rle_flush_q <= 1'b0;
      rd_req_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      dly_q       <= dly_d;
      rem_q       <= rem_d;
      triggered_q <= triggered_d;
      rle_flush_q <= rle_flush_d;
      rd_req_q    <= rd_req_d;
      done_q      <= done_d;
    end
  end

  assign bus.mem_wr     = mem_wr_w;
  assign bus.mem_wraddr = wr_ptr_q;
  assign bus.rd_req     = rd_req_q;
  assign bus.rd_addr    = rd_ptr_q;
  assign bus.rle_flush  = rle_flush_q;
  assign bus.armed      = (state_q == S_ARMED);
  assign bus.triggered  = triggered_q;
  assign bus.done       = done_q;

endmodule

`default_nettype wire
